// File: rtl/ict_pkg.sv
// Shared types and default parameters for the instruction change tracker.
package ict_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        TRACK = 1'b1
    } ict_state_t;

    localparam int ICT_WIDTH = 32;
    localparam int ICT_DEPTH = 4;
    localparam int ICT_CNT_W = 8;

endpackage

// File: rtl/ict_cam_match.sv
// Compares one word against a set of entries.
// Returns the valid-gated hit vector, a hit summary and the lowest hit index.
module ict_cam_match
    import ict_pkg::*;
#(
    parameter int WIDTH = ICT_WIDTH,
    parameter int DEPTH = ICT_DEPTH,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [WIDTH-1:0]            key,
    input  logic [DEPTH-1:0][WIDTH-1:0] entries,
    input  logic [DEPTH-1:0]            valid,
    output logic [DEPTH-1:0]            hit,
    output logic                        any_hit,
    output logic [IDX_W-1:0]            idx
);

    // Per-entry compare, then scan from the top so the lowest index wins.
    always_comb begin
        hit     = '0;
        idx     = '0;
        any_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = valid[i] && (entries[i] == key);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx = i[IDX_W-1:0];
            end else begin
                idx = idx;
            end
        end
        any_hit = |hit;
    end

endmodule

// File: rtl/instruction_change_tracker.sv
// Tracks instruction changes: history, repeat count and a change-event handshake.
// Define ICT_HISTORY_EN for the full DEPTH-entry history; otherwise only the newest entry is kept.
module instruction_change_tracker
    import ict_pkg::*;
#(
    parameter int WIDTH = ICT_WIDTH,
    parameter int DEPTH = ICT_DEPTH,
    parameter int CNT_W = ICT_CNT_W
) (
    input  logic                     HF_CLK,
    input  logic                     RST,
    input  logic                     CLR,
    input  logic                     EN,
    input  logic [WIDTH-1:0]         INSTRUCTION,
    output logic                     EQU,
    output logic                     NOT_EQU,
    output logic                     NEW_PULSE,
    output logic                     HIST_HIT,
    output logic [$clog2(DEPTH)-1:0] HIT_IDX,
    output logic [CNT_W-1:0]         REPEAT_CNT,
    output logic [$clog2(DEPTH):0]   HIST_CNT,
    output logic                     EVT_VALID,
    output logic [WIDTH-1:0]         EVT_DATA,
    input  logic                     EVT_READY,
    output logic                     OVF
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int HC_W  = IDX_W + 1;
`ifdef ICT_HISTORY_EN
    localparam int HD = DEPTH;
`else
    localparam int HD = 1;
`endif
    localparam logic [HC_W-1:0] HC_MAX = HC_W'(HD);

    ict_state_t                 state_q, state_d;
    logic [HD-1:0][WIDTH-1:0]   hist_q, hist_d;
    logic [HC_W-1:0]            hist_cnt_q, hist_cnt_d;
    logic [CNT_W-1:0]           repeat_q, repeat_d;
    logic                       new_pulse_q, new_pulse_d;
    logic                       hist_hit_q, hist_hit_d;
    logic [IDX_W-1:0]           hit_idx_q, hit_idx_d;
    logic                       evt_valid_q, evt_valid_d;
    logic [WIDTH-1:0]           evt_data_q, evt_data_d;
    logic                       ovf_q, ovf_d;

    logic                       track_s;
    logic                       equ_s;
    logic                       change_s;
    logic                       hist_hit_s;
    logic [IDX_W-1:0]           hist_idx_s;
    logic [0:0]                 unused_equ_hit_s;
    logic [0:0]                 unused_equ_idx_s;

    assign track_s = (state_q == TRACK);

    ict_cam_match #(
        .WIDTH (WIDTH),
        .DEPTH (1)
    ) u_equ_match (
        .key     (INSTRUCTION),
        .entries (hist_q[0]),
        .valid   (track_s),
        .hit     (unused_equ_hit_s),
        .any_hit (equ_s),
        .idx     (unused_equ_idx_s)
    );

`ifdef ICT_HISTORY_EN
    logic [HD-1:0] hist_valid_s;
    logic [HD-1:0] unused_hist_vec_s;

    // Entry 0 is excluded: a match there is equality, not a history hit.
    always_comb begin
        hist_valid_s = '0;
        for (int i = 1; i < HD; i++) begin
            hist_valid_s[i] = (hist_cnt_q > HC_W'(i));
        end
    end

    ict_cam_match #(
        .WIDTH (WIDTH),
        .DEPTH (HD)
    ) u_hist_match (
        .key     (INSTRUCTION),
        .entries (hist_q),
        .valid   (hist_valid_s),
        .hit     (unused_hist_vec_s),
        .any_hit (hist_hit_s),
        .idx     (hist_idx_s)
    );
`else
    assign hist_hit_s = 1'b0;
    assign hist_idx_s = '0;
`endif

    assign change_s = EN && !equ_s;

    // Next-state: clear, accepted change, or repeat/idle with handshake draining.
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        hist_cnt_d  = hist_cnt_q;
        repeat_d    = repeat_q;
        new_pulse_d = 1'b0;
        hist_hit_d  = hist_hit_q;
        hit_idx_d   = hit_idx_q;
        evt_valid_d = evt_valid_q;
        evt_data_d  = evt_data_q;
        ovf_d       = ovf_q;
        if (CLR) begin
            state_d     = EMPTY;
            hist_d      = '0;
            hist_cnt_d  = '0;
            repeat_d    = '0;
            hist_hit_d  = 1'b0;
            hit_idx_d   = '0;
            evt_valid_d = 1'b0;
            evt_data_d  = '0;
            ovf_d       = 1'b0;
        end else if (change_s) begin
            for (int i = HD - 1; i > 0; i--) begin
                hist_d[i] = hist_q[i-1];
            end
            hist_d[0]   = INSTRUCTION;
            state_d     = TRACK;
            hist_cnt_d  = (hist_cnt_q == HC_MAX) ? hist_cnt_q : hist_cnt_q + 1'b1;
            repeat_d    = '0;
            new_pulse_d = 1'b1;
            hist_hit_d  = hist_hit_s;
            hit_idx_d   = hist_idx_s;
            // A stalled consumer keeps its pending event; the new one is lost.
            if (!evt_valid_q || EVT_READY) begin
                evt_valid_d = 1'b1;
                evt_data_d  = INSTRUCTION;
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            if (EN) begin
                repeat_d = (repeat_q == {CNT_W{1'b1}}) ? repeat_q : repeat_q + 1'b1;
            end else begin
                repeat_d = repeat_q;
            end
            if (evt_valid_q && EVT_READY) begin
                evt_valid_d = 1'b0;
            end else begin
                evt_valid_d = evt_valid_q;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge HF_CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= EMPTY;
            hist_q      <= '0;
            hist_cnt_q  <= '0;
            repeat_q    <= '0;
            new_pulse_q <= 1'b0;
            hist_hit_q  <= 1'b0;
            hit_idx_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            hist_cnt_q  <= hist_cnt_d;
            repeat_q    <= repeat_d;
            new_pulse_q <= new_pulse_d;
            hist_hit_q  <= hist_hit_d;
            hit_idx_q   <= hit_idx_d;
            evt_valid_q <= evt_valid_d;
            evt_data_q  <= evt_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign EQU        = equ_s;
    assign NOT_EQU    = !equ_s;
    assign NEW_PULSE  = new_pulse_q;
    assign HIST_HIT   = hist_hit_q;
    assign HIT_IDX    = hit_idx_q;
    assign REPEAT_CNT = repeat_q;
    assign HIST_CNT   = hist_cnt_q;
    assign EVT_VALID  = evt_valid_q;
    assign EVT_DATA   = evt_data_q;
    assign OVF        = ovf_q;

endmodule

// File: doc/instruction_change_tracker.md
INSTRUCTION_CHANGE_TRACKER -- requirements
Module: instruction_change_tracker

Interface
REQ-001 SHALL have parameter WIDTH, default 32: instruction width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: history entries; power of two, at least 2.
REQ-003 SHALL have parameter CNT_W, default 8: repeat-counter width.
REQ-004 SHALL have port HF_CLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port CLR  in  1  synchronous clear.
REQ-007 SHALL have port EN  in  1  sample strobe for INSTRUCTION.
REQ-008 SHALL have port INSTRUCTION  in  WIDTH  current instruction.
REQ-009 SHALL have port EQU  out  1  INSTRUCTION equals newest history entry.
REQ-010 SHALL have port NOT_EQU  out  1  inverse of EQU.
REQ-011 SHALL have port NEW_PULSE  out  1  one-cycle pulse after an accepted change.
REQ-012 SHALL have port HIST_HIT  out  1  last accepted change matched an older history entry.
REQ-013 SHALL have port HIT_IDX  out  $clog2(DEPTH)  index of that match.
REQ-014 SHALL have port REPEAT_CNT  out  CNT_W  consecutive equal samples since the last change.
REQ-015 SHALL have port HIST_CNT  out  $clog2(DEPTH)+1  number of valid history entries.
REQ-016 SHALL have ports EVT_VALID out 1, EVT_DATA out WIDTH, EVT_READY in 1: change-event handshake.
REQ-017 SHALL have port OVF  out  1  sticky flag: change event dropped.

Function
REQ-018 SHALL implement states EMPTY (HIST_CNT=0) and TRACK (HIST_CNT>0).
REQ-019 EQU SHALL be combinational: (INSTRUCTION==HIST[0]) && TRACK; EQU SHALL be 0 in EMPTY.
REQ-020 Accepted change = EN && !EQU at a clock edge; in EMPTY the first EN sample SHALL always be a change, then EMPTY->TRACK.
REQ-021 On a change: HIST shifts (HIST[i+1]<=HIST[i], HIST[0]<=INSTRUCTION); HIST_CNT increments, saturating at DEPTH; REPEAT_CNT<=0; NEW_PULSE<=1 the next cycle (latency 1).
REQ-022 On a change: HIST_HIT<=match of INSTRUCTION against valid entries 1..DEPTH-1, evaluated before the shift; HIT_IDX<=lowest matching index, else 0. Both SHALL hold until the next change.
REQ-023 EN && EQU: REPEAT_CNT increments, saturating at 2^CNT_W-1; NEW_PULSE<=0.
REQ-024 EN=0: all state SHALL hold; NEW_PULSE<=0.
REQ-025 On a change with (!EVT_VALID || EVT_READY): EVT_DATA<=INSTRUCTION, EVT_VALID<=1.
REQ-026 On a change with EVT_VALID && !EVT_READY: the pending event SHALL be kept and OVF<=1.
REQ-027 With no change and EVT_VALID && EVT_READY: EVT_VALID<=0.
REQ-028 EVT_DATA SHALL be stable while EVT_VALID && !EVT_READY.
REQ-029 CLR SHALL take priority over EN, returning every register to its reset value (state EMPTY) at the next edge.

Reset
REQ-030 While RST=0, outputs SHALL be forced immediately: HIST_CNT=0, state EMPTY, EQU=0, NOT_EQU=1, NEW_PULSE=0, HIST_HIT=0, HIT_IDX=0, REPEAT_CNT=0, EVT_VALID=0, EVT_DATA=0, OVF=0; all HIST entries SHALL be 0.
REQ-031 Reset asserted mid-handshake SHALL drop the pending event without setting OVF.

Configuration
REQ-032 Macro ICT_HISTORY_EN defined: DEPTH-entry history with HIST_HIT and HIT_IDX as specified.
REQ-033 Macro ICT_HISTORY_EN undefined: only HIST[0] is stored; HIST_HIT=0 and HIT_IDX=0 constant; HIST_CNT saturates at 1; all other behaviour unchanged.

Structure
REQ-034 Package ict_pkg SHALL hold the state enum ict_state_t (EMPTY, TRACK) and the default constants ICT_WIDTH=32, ICT_DEPTH=4, ICT_CNT_W=8.
REQ-035 Sub-module ict_cam_match SHALL compare one WIDTH-bit word against DEPTH entries and return a valid-gated hit vector plus lowest index; used for both EQU and HIST_HIT.

Verification
REQ-036 Reset, then EN=1, INSTRUCTION=0x00000000 -> change accepted (EMPTY overrides equality with the reset value); NEW_PULSE=1 next cycle; HIST_CNT=1; EVT_DATA=0.
REQ-037 Sequence A=0xE3A00001, B=0xE2811001, C=0xE1A0F00E, then A again -> HIST_HIT=1, HIT_IDX=2, HIST_CNT=4.
REQ-038 Hold 0xE3A00001 with EN=1 for 300 cycles (CNT_W=8) -> REPEAT_CNT saturates at 255; NEW_PULSE stays 0.
REQ-039 EVT_READY=0, two changes -> first event held, OVF=1; then EVT_READY=1 for one cycle with no change -> EVT_VALID=0, OVF stays 1.
REQ-040 CLR=1 together with EN=1 and a new value -> state EMPTY, HIST_CNT=0, no NEW_PULSE; async RST pulse mid-cycle -> all outputs at reset values before the next edge.
REQ-041 Build without ICT_HISTORY_EN, rerun REQ-037 -> HIST_HIT=0, HIST_CNT=1.
